// File: rtl/sync_event_capture_pkg.sv
// sync_event_pkg: edge codes, filter state encoding and event record sizing shared by the capture block.
package sync_event_pkg;
  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;
  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} filt_state_t;
  function automatic int rec_width(input int ts_width);
    return ts_width + 1;
  endfunction
endpackage

// File: rtl/sync_event_capture_if.sv
// sync_event_capture_if: valid/ready event stream carrying {edge_type, timestamp} records.
interface sync_event_capture_if #(parameter int TS_WIDTH = 8);
  logic out_valid;
  logic out_ready;
  logic [sync_event_pkg::rec_width(TS_WIDTH)-1:0] out_data;
  modport master(output out_valid, output out_data, input out_ready);
  modport slave(input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/sync_event_capture_fifo.sv
// sync_event_fifo: small register FIFO whose head entry is presented straight from flops.
module sync_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ;
  logic wr_en, rd_en;
  assign full  = occ == (AW+1)'(DEPTH);
  assign empty = occ == '0;
  assign rd_en = pop && !empty;
  // a full queue still accepts a write when the head leaves in the same cycle
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) mem[wr_ptr] <= din;
      wr_ptr <= wr_en ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd_en ? rd_ptr + AW'(1) : rd_ptr;
      occ    <= occ + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
endmodule

// File: rtl/sync_event_capture.sv
// sync_event_capture: glitch-filters a synchronized level and queues timestamped rise/fall events.
module sync_event_capture
  import sync_event_pkg::*;
#(
  parameter int FILT_CYCLES = 2,
  parameter int TS_WIDTH    = 8,
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync_in,
  input  logic                 clr,
  sync_event_capture_if.master evt,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] event_cnt,
  output logic                 filt_level
);
  localparam int RW = rec_width(TS_WIDTH);
  localparam int FW = $clog2(FILT_CYCLES + 1);
  filt_state_t state, state_nxt;
  logic [FW-1:0] cnt, cnt_nxt;
  logic [TS_WIDTH-1:0] ts;
  logic stable, diff, det, push, pop, full, empty, accept;
  assign stable     = state == STABLE_LO || state == STABLE_HI;
  assign filt_level = state == STABLE_HI || state == PEND_LO;
  assign diff       = sync_in != filt_level;
  // the count tracks differing samples already taken; det fires on the one that completes the run
  always_comb begin
    det       = diff && (stable ? FILT_CYCLES == 1 : 32'(cnt) + 1 >= FILT_CYCLES);
    cnt_nxt   = stable ? FW'(1) : cnt + FW'(1);
    state_nxt = !diff ? (filt_level ? STABLE_HI : STABLE_LO) :
                det   ? (filt_level ? STABLE_LO : STABLE_HI) :
                        (filt_level ? PEND_LO : PEND_HI);
  end
  assign push          = det && !clr;
  assign pop           = evt.out_valid && evt.out_ready;
  assign accept        = push && (!full || pop);
  assign evt.out_valid = !empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STABLE_LO;
      cnt       <= '0;
      ts        <= '0;
      overflow  <= 1'b0;
      event_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ts        <= ts + TS_WIDTH'(1);
      overflow  <= clr ? 1'b0 : overflow || (push && full && !pop);
      event_cnt <= clr ? '0 : (accept && event_cnt != '1) ? event_cnt + CNT_WIDTH'(1) : event_cnt;
    end
  end
  sync_event_fifo #(.DEPTH(DEPTH), .WIDTH(RW)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .push (push),
    .pop  (pop),
    .din  ({filt_level ? EDGE_FALL : EDGE_RISE, ts}),
    .dout (evt.out_data),
    .full (full),
    .empty(empty)
  );
endmodule

// File: tb/tb_sync_event_capture.sv
// tb_sync_event_capture: directed scenarios for the filtered event capture block.
module tb_sync_event_capture;
  import sync_event_pkg::*;
  logic clk = 0, rst_n = 0, sync_in = 0, clr = 0;
  logic overflow, filt_level;
  logic [7:0] event_cnt, m_ts;
  logic [8:0] rec [6];
  logic [8:0] exp_q [4];
  logic [8:0] r;
  int cmp = 0, err = 0;

  sync_event_capture_if #(.TS_WIDTH(8)) bus();

  sync_event_capture dut (
    .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .clr(clr), .evt(bus),
    .overflow(overflow), .event_cnt(event_cnt), .filt_level(filt_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_ts <= 8'd0;
    else m_ts <= m_ts + 8'd1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic edge_evt(output logic [8:0] rr);
    sync_in = ~sync_in;
    step();
    step();
    rr = {sync_in, 8'(m_ts - 8'd1)};
  endtask

  task automatic pop_one;
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
  endtask

  task automatic test_reset;
    #12;
    cmp++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL rst_valid: got %0h exp 0", bus.out_valid); end
    cmp++; if (bus.out_data !== 9'h000) begin err++; $display("FAIL rst_data: got %0h exp 0", bus.out_data); end
    cmp++; if (overflow !== 1'b0) begin err++; $display("FAIL rst_ovf: got %0h exp 0", overflow); end
    cmp++; if (event_cnt !== 8'd0) begin err++; $display("FAIL rst_cnt: got %0d exp 0", event_cnt); end
    cmp++; if (filt_level !== 1'b0) begin err++; $display("FAIL rst_level: got %0h exp 0", filt_level); end
    cmp++; if (dut.state !== STABLE_LO) begin err++; $display("FAIL rst_state: got %0d exp %0d", dut.state, STABLE_LO); end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_rise;
    sync_in = 1;
    step();
    cmp++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL rise_early_valid: got %0h exp 0", bus.out_valid); end
    cmp++; if (dut.state !== PEND_HI) begin err++; $display("FAIL rise_pend: got %0d exp %0d", dut.state, PEND_HI); end
    step();
    rec[0] = {1'b1, 8'(m_ts - 8'd1)};
    cmp++; if (bus.out_valid !== 1'b1) begin err++; $display("FAIL rise_valid: got %0h exp 1", bus.out_valid); end
    cmp++; if (bus.out_data !== rec[0]) begin err++; $display("FAIL rise_data: got %0h exp %0h", bus.out_data, rec[0]); end
    cmp++; if (filt_level !== 1'b1) begin err++; $display("FAIL rise_level: got %0h exp 1", filt_level); end
    repeat (3) step();
    cmp++; if (bus.out_data !== rec[0]) begin err++; $display("FAIL rise_hold: got %0h exp %0h", bus.out_data, rec[0]); end
    cmp++; if (event_cnt !== 8'd1) begin err++; $display("FAIL rise_cnt: got %0d exp 1", event_cnt); end
    pop_one();
    cmp++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL rise_pop: got %0h exp 0", bus.out_valid); end
    edge_evt(r);
    cmp++; if (bus.out_data !== r || r[8] !== 1'b0) begin err++; $display("FAIL fall_data: got %0h exp %0h", bus.out_data, r); end
    pop_one();
  endtask

  task automatic test_glitch;
    sync_in = 1;
    step();
    sync_in = 0;
    step();
    cmp++; if (dut.state !== STABLE_LO) begin err++; $display("FAIL glitch_state: got %0d exp %0d", dut.state, STABLE_LO); end
    step();
    cmp++; if (filt_level !== 1'b0) begin err++; $display("FAIL glitch_level: got %0h exp 0", filt_level); end
    cmp++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL glitch_valid: got %0h exp 0", bus.out_valid); end
    cmp++; if (event_cnt !== 8'd2) begin err++; $display("FAIL glitch_cnt: got %0d exp 2", event_cnt); end
  endtask

  task automatic test_overflow;
    clr = 1;
    step();
    clr = 0;
    cmp++; if (event_cnt !== 8'd0) begin err++; $display("FAIL ovf_clr_cnt: got %0d exp 0", event_cnt); end
    for (int i = 0; i < 6; i++) begin
      edge_evt(rec[i]);
      if (i == 3) begin
        cmp++; if (overflow !== 1'b0) begin err++; $display("FAIL ovf_early: got %0h exp 0", overflow); end
      end
    end
    cmp++; if (overflow !== 1'b1) begin err++; $display("FAIL ovf_flag: got %0h exp 1", overflow); end
    cmp++; if (event_cnt !== 8'd4) begin err++; $display("FAIL ovf_cnt: got %0d exp 4", event_cnt); end
    cmp++; if (bus.out_data !== rec[0]) begin err++; $display("FAIL ovf_head: got %0h exp %0h", bus.out_data, rec[0]); end
  endtask

  task automatic test_back_to_back;
    sync_in = 1;
    step();
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    exp_q = '{rec[1], rec[2], rec[3], {1'b1, 8'(m_ts - 8'd1)}};
    cmp++; if (event_cnt !== 8'd5) begin err++; $display("FAIL b2b_cnt: got %0d exp 5", event_cnt); end
    for (int i = 0; i < 4; i++) begin
      cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[i]) begin err++; $display("FAIL b2b_drain%0d: got %0h exp %0h", i, bus.out_data, exp_q[i]); end
      pop_one();
    end
    cmp++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL b2b_empty: got %0h exp 0", bus.out_valid); end
    cmp++; if (overflow !== 1'b1) begin err++; $display("FAIL b2b_sticky: got %0h exp 1", overflow); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 300 && m_ts != 8'd254; i++) step();
    edge_evt(r);
    cmp++; if (bus.out_data !== 9'h0FF) begin err++; $display("FAIL wrap_255: got %0h exp 0ff", bus.out_data); end
    pop_one();
    for (int i = 0; i < 300 && m_ts != 8'd255; i++) step();
    edge_evt(r);
    cmp++; if (bus.out_data !== 9'h100) begin err++; $display("FAIL wrap_0: got %0h exp 100", bus.out_data); end
    pop_one();
  endtask

  task automatic test_clr_reset;
    for (int i = 0; i < 3; i++) edge_evt(rec[i]);
    cmp++; if (event_cnt !== 8'd10) begin err++; $display("FAIL clr_pre_cnt: got %0d exp 10", event_cnt); end
    clr = 1;
    step();
    clr = 0;
    cmp++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL clr_valid: got %0h exp 0", bus.out_valid); end
    cmp++; if (overflow !== 1'b0) begin err++; $display("FAIL clr_ovf: got %0h exp 0", overflow); end
    cmp++; if (event_cnt !== 8'd0) begin err++; $display("FAIL clr_cnt: got %0d exp 0", event_cnt); end
    sync_in = 1;
    step();
    clr = 1;
    step();
    clr = 0;
    cmp++; if (bus.out_valid !== 1'b0 || event_cnt !== 8'd0) begin err++; $display("FAIL clr_discard: got valid %0h cnt %0d exp 0 0", bus.out_valid, event_cnt); end
    cmp++; if (filt_level !== 1'b1 || dut.state !== STABLE_HI) begin err++; $display("FAIL clr_keep_fsm: got %0h/%0d exp 1/%0d", filt_level, dut.state, STABLE_HI); end
    edge_evt(r);
    sync_in = 1;
    step();
    cmp++; if (dut.state !== PEND_HI) begin err++; $display("FAIL pre_rst_pend: got %0d exp %0d", dut.state, PEND_HI); end
    rst_n = 0;
    #2;
    cmp++; if (dut.state !== STABLE_LO || filt_level !== 1'b0) begin err++; $display("FAIL rst_mid_fsm: got %0d/%0h exp %0d/0", dut.state, filt_level, STABLE_LO); end
    cmp++; if (bus.out_valid !== 1'b0 || event_cnt !== 8'd0) begin err++; $display("FAIL rst_mid_q: got %0h/%0d exp 0/0", bus.out_valid, event_cnt); end
    rst_n = 1;
    step();
    cmp++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL post_rst_early: got %0h exp 0", bus.out_valid); end
    step();
    cmp++; if (bus.out_data !== 9'h101 || bus.out_valid !== 1'b1) begin err++; $display("FAIL post_rst_rise: got %0h exp 101", bus.out_data); end
    cmp++; if (event_cnt !== 8'd1) begin err++; $display("FAIL post_rst_cnt: got %0d exp 1", event_cnt); end
  endtask

  initial begin
    bus.out_ready = 0;
    test_reset();
    test_rise();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_clr_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
